// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: bus widths, state
// encoding and the default access timeout.
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  // Cycles to wait for port_ack before the access is abandoned.
  localparam int unsigned TIMEOUT_DEFAULT = 255;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    IF_BUSY  = 3'd1,
    MEM_BUSY = 3'd2,
    IF_DONE  = 3'd3,
    MEM_DONE = 3'd4
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the pipeline (fetch + load/store stages), the
// shared memory port and the arbiter. The arbiter uses the slave view; the
// pipeline/memory environment uses the master view.
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  // Instruction fetch side
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_stall;

  // Load/store side
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_byte_en;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_stall;

  // Shared memory port
  logic              port_req;
  logic              port_we;
  logic [ADDR_W-1:0] port_addr;
  logic [DATA_W-1:0] port_wdata;
  logic [BE_W-1:0]   port_byte_en;
  logic              port_ack;
  logic [DATA_W-1:0] port_rdata;

  // Timeout indication
  logic              bus_err;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_byte_en,
    input  port_ack, port_rdata,
    output if_rdata, if_stall, mem_rdata, mem_stall,
    output port_req, port_we, port_addr, port_wdata, port_byte_en, bus_err
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_byte_en,
    output port_ack, port_rdata,
    input  if_rdata, if_stall, mem_rdata, mem_stall,
    input  port_req, port_we, port_addr, port_wdata, port_byte_en, bus_err
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared memory port between instruction fetch and
// load/store. Load/store has fixed priority. Each access is registered on
// grant, held on the port until ack or timeout, and followed by one DONE
// cycle in which the served side's stall is released.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  arb_state_t        state_q, state_d;
  logic [31:0]       cnt_q, cnt_d, cnt_inc;
  logic              grant_if, grant_mem;
  logic              done_ack, done_tmo;
  logic              mem_stall_w;

  logic              port_we_q;
  logic [ADDR_W-1:0] port_addr_q;
  logic [DATA_W-1:0] port_wdata_q;
  logic [BE_W-1:0]   port_byte_en_q;
  logic [DATA_W-1:0] if_rdata_q, mem_rdata_q;

  assign cnt_inc = cnt_q + 32'd1;

  // Next state: arbitrate in IDLE/DONE, finish on ack or timeout while busy.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    grant_if  = 1'b0;
    grant_mem = 1'b0;
    done_ack  = 1'b0;
    done_tmo  = 1'b0;
    case (state_q)
      IDLE, IF_DONE, MEM_DONE: begin
        if (bus.mem_req) begin
          state_d   = MEM_BUSY;
          grant_mem = 1'b1;
          cnt_d     = '0;
        end else if (bus.if_req) begin
          state_d  = IF_BUSY;
          grant_if = 1'b1;
          cnt_d    = '0;
        end else begin
          state_d = IDLE;
        end
      end
      IF_BUSY, MEM_BUSY: begin
        cnt_d = cnt_inc;
        // An ack in the last allowed cycle still wins over the timeout.
        if (bus.port_ack) begin
          done_ack = 1'b1;
        end else if (cnt_inc == TIMEOUT) begin
          done_tmo = 1'b1;
        end
        if (bus.port_ack || (cnt_inc == TIMEOUT)) begin
          state_d = (state_q == IF_BUSY) ? IF_DONE : MEM_DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and wait-counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the granted request; it stays untouched for the whole access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      port_we_q      <= 1'b0;
      port_addr_q    <= '0;
      port_wdata_q   <= '0;
      port_byte_en_q <= '0;
    end else if (grant_mem) begin
      port_we_q      <= bus.mem_we;
      port_addr_q    <= bus.mem_addr;
      port_wdata_q   <= bus.mem_wdata;
      port_byte_en_q <= bus.mem_byte_en;
    end else if (grant_if) begin
      port_we_q      <= 1'b0;
      port_addr_q    <= bus.if_addr;
      port_wdata_q   <= '0;
      port_byte_en_q <= '0;
    end
  end

  // Return data: ack data on completion, zero on timeout. A store that
  // completes normally leaves the last load result in place.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      if (state_q == IF_BUSY) begin
        if (done_ack)      if_rdata_q <= bus.port_rdata;
        else if (done_tmo) if_rdata_q <= '0;
      end
      if (state_q == MEM_BUSY) begin
        if (done_ack && !port_we_q) mem_rdata_q <= bus.port_rdata;
        else if (done_tmo)          mem_rdata_q <= '0;
      end
    end
  end

  assign mem_stall_w      = bus.mem_req && (state_q != MEM_DONE);

  assign bus.mem_stall    = mem_stall_w;
  assign bus.if_stall     = (bus.if_req && (state_q != IF_DONE)) || mem_stall_w;
  assign bus.port_req     = (state_q == IF_BUSY) || (state_q == MEM_BUSY);
  assign bus.port_we      = port_we_q;
  assign bus.port_addr    = port_addr_q;
  assign bus.port_wdata   = port_wdata_q;
  assign bus.port_byte_en = port_byte_en_q;
  assign bus.if_rdata     = if_rdata_q;
  assign bus.mem_rdata    = mem_rdata_q;
  assign bus.bus_err      = done_tmo;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (TIMEOUT overridden to 4). A cycle
// table drives inputs after each rising edge and checks outputs at the
// falling edge; reset behaviour is covered by hand-written sequences.
module tb_mem_port_arbiter;

  typedef struct {
    string       name;
    logic        ifr;
    logic [31:0] ifa;
    logic        memr;
    logic        we;
    logic [31:0] maddr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ack;
    logic [31:0] prd;
    logic        e_ifs;
    logic        e_mems;
    logic        e_preq;
    logic        e_pwe;
    logic [31:0] e_paddr;
    logic [31:0] e_pwd;
    logic [3:0]  e_pbe;
    logic        e_err;
    logic [31:0] e_ifrd;
    logic [31:0] e_memrd;
  } vec_t;

  logic clk;
  logic reset;
  int   nchk;
  int   nerr;
  vec_t vecs[$];

  mem_port_arbiter_if bus_if();

  mem_port_arbiter #(.TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm,
                     input logic ifr, input logic [31:0] ifa, input logic memr, input logic we,
                     input logic [31:0] maddr, input logic [31:0] wdata, input logic [3:0] be,
                     input logic ack, input logic [31:0] prd,
                     input logic e_ifs, input logic e_mems, input logic e_preq, input logic e_pwe,
                     input logic [31:0] e_paddr, input logic [31:0] e_pwd, input logic [3:0] e_pbe,
                     input logic e_err, input logic [31:0] e_ifrd, input logic [31:0] e_memrd);
    vec_t v;
    v.name = nm; v.ifr = ifr; v.ifa = ifa; v.memr = memr; v.we = we; v.maddr = maddr;
    v.wdata = wdata; v.be = be; v.ack = ack; v.prd = prd;
    v.e_ifs = e_ifs; v.e_mems = e_mems; v.e_preq = e_preq; v.e_pwe = e_pwe;
    v.e_paddr = e_paddr; v.e_pwd = e_pwd; v.e_pbe = e_pbe; v.e_err = e_err;
    v.e_ifrd = e_ifrd; v.e_memrd = e_memrd;
    vecs.push_back(v);
  endtask

  task automatic drive_idle();
    bus_if.if_req = 1'b0;      bus_if.if_addr = '0;
    bus_if.mem_req = 1'b0;     bus_if.mem_we = 1'b0;
    bus_if.mem_addr = '0;      bus_if.mem_wdata = '0;
    bus_if.mem_byte_en = '0;   bus_if.port_ack = 1'b0;
    bus_if.port_rdata = '0;
  endtask

  initial begin
    nchk = 0;
    nerr = 0;
    reset = 1'b1;
    drive_idle();

    // Table: inputs (ifr ifa memr we maddr wdata be ack prd) then expected
    // outputs (if_stall mem_stall port_req port_we port_addr port_wdata
    // port_byte_en bus_err if_rdata mem_rdata). Port fields are checked only
    // while port_req is expected high; port_wdata only for stores.
    // Fetch, ack on the 2nd busy cycle, then a second fetch from IF_DONE.
    add("if_grant",   1,32'h100, 0,0,0,0,4'h0, 0,0,            1,0,0,0,0,0,4'h0,0, 32'h0,0);
    add("if_busy",    1,32'h100, 0,0,0,0,4'h0, 0,0,            1,0,1,0,32'h100,0,4'h0,0, 32'h0,0);
    add("if_ack",     1,32'h100, 0,0,0,0,4'h0, 1,32'h2408_0001, 1,0,1,0,32'h100,0,4'h0,0, 32'h0,0);
    add("if_done",    1,32'h104, 0,0,0,0,4'h0, 0,0,            0,0,0,0,0,0,4'h0,0, 32'h2408_0001,0);
    add("if_b2b_ack", 1,32'h104, 0,0,0,0,4'h0, 1,32'h1111_2222, 1,0,1,0,32'h104,0,4'h0,0, 32'h2408_0001,0);
    add("ack_in_done",0,0,       0,0,0,0,4'h0, 1,32'hFFFF_FFFF, 0,0,0,0,0,0,4'h0,0, 32'h1111_2222,0);
    add("ack_in_idle",0,0,       0,0,0,0,4'h0, 1,32'hFFFF_FFFF, 0,0,0,0,0,0,4'h0,0, 32'h1111_2222,0);
    // Simultaneous requests: MEM load first, IF waits for mem_req=0.
    add("both_req",   1,32'h200, 1,0,32'h40,0,4'hF, 0,0,       1,1,0,0,0,0,4'h0,0, 32'h1111_2222,0);
    add("mem_ack",    1,32'h200, 1,0,32'h40,0,4'hF, 1,32'hDEAD_BEEF, 1,1,1,0,32'h40,0,4'hF,0, 32'h1111_2222,0);
    add("if_after_mem",1,32'h200,0,0,0,0,4'h0, 0,0,            1,0,0,0,0,0,4'h0,0, 32'h1111_2222,32'hDEAD_BEEF);
    add("if_ack2",    1,32'h200, 0,0,0,0,4'h0, 1,32'h3333_4444, 1,0,1,0,32'h200,0,4'h0,0, 32'h1111_2222,32'hDEAD_BEEF);
    add("if_done2",   0,0,       0,0,0,0,4'h0, 0,0,            0,0,0,0,0,0,4'h0,0, 32'h3333_4444,32'hDEAD_BEEF);
    // Store; request inputs wiggle while busy, port must not follow them.
    add("st_grant",   0,0, 1,1,32'h80,32'h0000_ABCD,4'h3, 0,0, 1,1,0,0,0,0,4'h0,0, 32'h3333_4444,32'hDEAD_BEEF);
    add("st_busy1",   0,0, 1,0,32'hFFFF_FFF0,32'h1234,4'hC, 0,0, 1,1,1,1,32'h80,32'h0000_ABCD,4'h3,0, 32'h3333_4444,32'hDEAD_BEEF);
    add("st_busy2",   0,0, 1,0,32'hFFFF_FFF0,32'h1234,4'hC, 0,0, 1,1,1,1,32'h80,32'h0000_ABCD,4'h3,0, 32'h3333_4444,32'hDEAD_BEEF);
    add("st_ack",     0,0, 1,0,32'hFFFF_FFF0,32'h1234,4'hC, 1,32'h5555_6666, 1,1,1,1,32'h80,32'h0000_ABCD,4'h3,0, 32'h3333_4444,32'hDEAD_BEEF);
    add("st_done",    0,0, 0,0,0,0,4'h0, 0,0,                  0,0,0,0,0,0,4'h0,0, 32'h3333_4444,32'hDEAD_BEEF);
    // Load that times out after 4 busy cycles.
    add("to_grant",   0,0, 1,0,32'hC0,0,4'hF, 0,0,             1,1,0,0,0,0,4'h0,0, 32'h3333_4444,32'hDEAD_BEEF);
    add("to_busy1",   0,0, 1,0,32'hC0,0,4'hF, 0,0,             1,1,1,0,32'hC0,0,4'hF,0, 32'h3333_4444,32'hDEAD_BEEF);
    add("to_busy2",   0,0, 1,0,32'hC0,0,4'hF, 0,0,             1,1,1,0,32'hC0,0,4'hF,0, 32'h3333_4444,32'hDEAD_BEEF);
    add("to_busy3",   0,0, 1,0,32'hC0,0,4'hF, 0,0,             1,1,1,0,32'hC0,0,4'hF,0, 32'h3333_4444,32'hDEAD_BEEF);
    add("to_err",     0,0, 1,0,32'hC0,0,4'hF, 0,0,             1,1,1,0,32'hC0,0,4'hF,1, 32'h3333_4444,32'hDEAD_BEEF);
    // Consecutive loads granted straight from MEM_DONE.
    add("to_done_b2b",0,0, 1,0,32'hC4,0,4'hF, 0,0,             0,0,0,0,0,0,4'h0,0, 32'h3333_4444,32'h0);
    add("b2b_ack",    0,0, 1,0,32'hC4,0,4'hF, 1,32'hCAFE_0001, 1,1,1,0,32'hC4,0,4'hF,0, 32'h3333_4444,32'h0);
    add("b2b_done",   0,0, 1,0,32'hC8,0,4'hF, 0,0,             0,0,0,0,0,0,4'h0,0, 32'h3333_4444,32'hCAFE_0001);
    // Ack in the timeout cycle is a normal completion.
    add("late_busy1", 0,0, 1,0,32'hC8,0,4'hF, 0,0,             1,1,1,0,32'hC8,0,4'hF,0, 32'h3333_4444,32'hCAFE_0001);
    add("late_busy2", 0,0, 1,0,32'hC8,0,4'hF, 0,0,             1,1,1,0,32'hC8,0,4'hF,0, 32'h3333_4444,32'hCAFE_0001);
    add("late_busy3", 0,0, 1,0,32'hC8,0,4'hF, 0,0,             1,1,1,0,32'hC8,0,4'hF,0, 32'h3333_4444,32'hCAFE_0001);
    add("ack_at_to",  0,0, 1,0,32'hC8,0,4'hF, 1,32'h0BAD_F00D, 1,1,1,0,32'hC8,0,4'hF,0, 32'h3333_4444,32'hCAFE_0001);
    add("late_done",  0,0, 0,0,0,0,4'h0, 0,0,                  0,0,0,0,0,0,4'h0,0, 32'h3333_4444,32'h0BAD_F00D);
    // Fetch timeout clears if_rdata only.
    add("ifto_grant", 1,32'h300, 0,0,0,0,4'h0, 0,0,            1,0,0,0,0,0,4'h0,0, 32'h3333_4444,32'h0BAD_F00D);
    add("ifto_busy1", 1,32'h300, 0,0,0,0,4'h0, 0,0,            1,0,1,0,32'h300,0,4'h0,0, 32'h3333_4444,32'h0BAD_F00D);
    add("ifto_busy2", 1,32'h300, 0,0,0,0,4'h0, 0,0,            1,0,1,0,32'h300,0,4'h0,0, 32'h3333_4444,32'h0BAD_F00D);
    add("ifto_busy3", 1,32'h300, 0,0,0,0,4'h0, 0,0,            1,0,1,0,32'h300,0,4'h0,0, 32'h3333_4444,32'h0BAD_F00D);
    add("ifto_err",   1,32'h300, 0,0,0,0,4'h0, 0,0,            1,0,1,0,32'h300,0,4'h0,1, 32'h3333_4444,32'h0BAD_F00D);
    add("ifto_done",  0,0,       0,0,0,0,4'h0, 0,0,            0,0,0,0,0,0,4'h0,0, 32'h0,32'h0BAD_F00D);

    // Reset state, and stall outputs following the requests during reset.
    #2;
    chk("rst port_req",  32'(bus_if.port_req), 0);
    chk("rst port_we",   32'(bus_if.port_we), 0);
    chk("rst port_addr", bus_if.port_addr, 0);
    chk("rst port_wdata",bus_if.port_wdata, 0);
    chk("rst port_be",   32'(bus_if.port_byte_en), 0);
    chk("rst if_rdata",  bus_if.if_rdata, 0);
    chk("rst mem_rdata", bus_if.mem_rdata, 0);
    chk("rst bus_err",   32'(bus_if.bus_err), 0);
    chk("rst if_stall",  32'(bus_if.if_stall), 0);
    chk("rst mem_stall", 32'(bus_if.mem_stall), 0);
    bus_if.mem_req = 1'b1;
    #1;
    chk("rst memreq mem_stall", 32'(bus_if.mem_stall), 1);
    chk("rst memreq if_stall",  32'(bus_if.if_stall), 1);
    bus_if.mem_req = 1'b0;
    bus_if.if_req  = 1'b1;
    #1;
    chk("rst ifreq if_stall",  32'(bus_if.if_stall), 1);
    chk("rst ifreq mem_stall", 32'(bus_if.mem_stall), 0);
    bus_if.if_req = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      bus_if.if_req      = vecs[i].ifr;
      bus_if.if_addr     = vecs[i].ifa;
      bus_if.mem_req     = vecs[i].memr;
      bus_if.mem_we      = vecs[i].we;
      bus_if.mem_addr    = vecs[i].maddr;
      bus_if.mem_wdata   = vecs[i].wdata;
      bus_if.mem_byte_en = vecs[i].be;
      bus_if.port_ack    = vecs[i].ack;
      bus_if.port_rdata  = vecs[i].prd;
      @(negedge clk);
      chk({vecs[i].name, " if_stall"},  32'(bus_if.if_stall),  32'(vecs[i].e_ifs));
      chk({vecs[i].name, " mem_stall"}, 32'(bus_if.mem_stall), 32'(vecs[i].e_mems));
      chk({vecs[i].name, " port_req"},  32'(bus_if.port_req),  32'(vecs[i].e_preq));
      chk({vecs[i].name, " bus_err"},   32'(bus_if.bus_err),   32'(vecs[i].e_err));
      chk({vecs[i].name, " if_rdata"},  bus_if.if_rdata,  vecs[i].e_ifrd);
      chk({vecs[i].name, " mem_rdata"}, bus_if.mem_rdata, vecs[i].e_memrd);
      if (vecs[i].e_preq) begin
        chk({vecs[i].name, " port_we"},   32'(bus_if.port_we),      32'(vecs[i].e_pwe));
        chk({vecs[i].name, " port_addr"}, bus_if.port_addr,         vecs[i].e_paddr);
        chk({vecs[i].name, " port_be"},   32'(bus_if.port_byte_en), 32'(vecs[i].e_pbe));
        if (vecs[i].e_pwe)
          chk({vecs[i].name, " port_wdata"}, bus_if.port_wdata, vecs[i].e_pwd);
      end
    end

    // Reset in the middle of a load, then a stray ack afterwards.
    @(posedge clk);
    #1;
    drive_idle();
    bus_if.mem_req     = 1'b1;
    bus_if.mem_addr    = 32'h1000;
    bus_if.mem_byte_en = 4'hF;
    @(negedge clk);
    chk("mr grant port_req", 32'(bus_if.port_req), 0);
    @(negedge clk);
    chk("mr busy port_req",  32'(bus_if.port_req), 1);
    chk("mr busy port_addr", bus_if.port_addr, 32'h1000);
    #2;
    reset = 1'b1;
    #1;
    chk("mr rst port_req",  32'(bus_if.port_req), 0);
    chk("mr rst port_addr", bus_if.port_addr, 0);
    chk("mr rst mem_rdata", bus_if.mem_rdata, 0);
    chk("mr rst if_rdata",  bus_if.if_rdata, 0);
    chk("mr rst bus_err",   32'(bus_if.bus_err), 0);
    chk("mr rst mem_stall", 32'(bus_if.mem_stall), 1);
    bus_if.mem_req = 1'b0;
    #1;
    chk("mr rst stall off", 32'(bus_if.mem_stall), 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    bus_if.port_ack   = 1'b1;
    bus_if.port_rdata = 32'h9999_9999;
    @(negedge clk);
    chk("mr stray port_req",  32'(bus_if.port_req), 0);
    chk("mr stray mem_stall", 32'(bus_if.mem_stall), 0);
    @(posedge clk);
    #1;
    bus_if.port_ack = 1'b0;
    bus_if.if_req   = 1'b1;
    bus_if.if_addr  = 32'h400;
    @(negedge clk);
    chk("mr after mem_rdata", bus_if.mem_rdata, 0);
    chk("mr after port_req",  32'(bus_if.port_req), 0);
    chk("mr after if_stall",  32'(bus_if.if_stall), 1);
    @(negedge clk);
    chk("mr idle grant port_req",  32'(bus_if.port_req), 1);
    chk("mr idle grant port_addr", bus_if.port_addr, 32'h400);
    chk("mr idle grant port_we",   32'(bus_if.port_we), 0);
    bus_if.port_ack   = 1'b1;
    bus_if.port_rdata = 32'h7777_0000;
    @(posedge clk);
    #1;
    bus_if.port_ack = 1'b0;
    @(negedge clk);
    chk("mr fetch if_rdata", bus_if.if_rdata, 32'h7777_0000);
    chk("mr fetch if_stall", 32'(bus_if.if_stall), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk  in  1  pipeline clock, all state on rising edge; reset  in  1  asynchronous active-high reset.
REQ-002 The block SHALL have these IF-side ports: if_req  in  1  fetch request; if_addr  in  32  fetch word address; if_rdata  out  32  fetched word; if_stall  out  1  freeze PC/IFID.
REQ-003 The block SHALL have these MEM-side ports: mem_req  in  1  load/store request from EX/MEM; mem_we  in  1  store; mem_addr  in  32; mem_wdata  in  32; mem_byte_en  in  4; mem_rdata  out  32  load data; mem_stall  out  1  freeze MEM/WB and upstream.
REQ-004 The block SHALL have these shared-port ports: port_req  out  1; port_we  out  1; port_addr  out  32; port_wdata  out  32; port_byte_en  out  4; port_ack  in  1  one-cycle completion; port_rdata  in  32  valid with port_ack.
REQ-005 The block SHALL have this error port: bus_err  out  1  one-cycle pulse on access timeout.
REQ-006 The block SHALL have this parameter: TIMEOUT, default 255, the maximum number of cycles waited for port_ack.

Function
REQ-007 The block SHALL implement an FSM with states IDLE, IF_BUSY, MEM_BUSY, IF_DONE, MEM_DONE.
REQ-008 In IDLE, IF_DONE or MEM_DONE, mem_req SHALL grant MEM_BUSY, else if_req SHALL grant IF_BUSY, else the next state SHALL be IDLE; MEM has fixed priority on a simultaneous request.
REQ-009 On grant, the block SHALL register the address, we, wdata and byte_en, and port_req SHALL be 1 from the next cycle until ack or timeout; port_we and port_byte_en SHALL be 0 for IF grants.
REQ-010 port_addr, port_wdata, port_byte_en and port_we SHALL stay constant while port_req=1.
REQ-011 On port_ack in MEM_BUSY/IF_BUSY, the block SHALL latch port_rdata into mem_rdata/if_rdata and go to MEM_DONE/IF_DONE; port_req SHALL be 0 in the DONE states.
REQ-012 mem_rdata and if_rdata SHALL hold their last value until the next completion of the same side; stores SHALL leave mem_rdata unchanged.
REQ-013 mem_stall SHALL be mem_req AND NOT (state==MEM_DONE), combinationally.
REQ-014 if_stall SHALL be (if_req AND NOT (state==IF_DONE)) OR mem_stall.
REQ-015 A pending IF request SHALL wait while MEM is served; IF SHALL be granted only in a cycle with mem_req=0.
REQ-016 A 32-bit wait counter SHALL clear on grant and increment each BUSY cycle.
REQ-017 When the counter reaches TIMEOUT without port_ack, the block SHALL: pulse bus_err for one cycle, drop port_req, load 32'h0000_0000 into the served side's rdata, and enter the matching DONE state.
REQ-018 port_ack arriving in IDLE or DONE SHALL be ignored.
REQ-019 port_ack coinciding with a timeout cycle SHALL count as a normal completion with no bus_err.
REQ-020 Total latency SHALL be 1 grant cycle, then N cycles to ack, then 1 DONE cycle; the minimum is 3 cycles from request to stall release.

Reset
REQ-021 On reset assertion, the block SHALL immediately set state=IDLE, port_req=0, port_we=0, port_addr=0, port_wdata=0, port_byte_en=0, if_rdata=0, mem_rdata=0, bus_err=0 and counter=0.
REQ-022 During reset, mem_stall and if_stall SHALL follow REQ-013/014 with state=IDLE.
REQ-023 An access interrupted by reset SHALL be abandoned, and a later stray port_ack SHALL be ignored per REQ-018.

Structure
REQ-024 The state encoding (3-bit) and the TIMEOUT default SHALL live in the shared CPU package.
REQ-025 The block SHALL be a single module with no sub-modules.

Verification
REQ-026 Bench: if_req=1, mem_req=0, ack after 2 cycles, rdata=32'h2408_0001 -> if_rdata=32'h2408_0001, if_stall low only in IF_DONE.
REQ-027 Bench: if_req and mem_req asserted together, mem_addr=32'h0000_0040, load, ack data 32'hDEAD_BEEF -> MEM served first, mem_rdata=32'hDEAD_BEEF, then IF granted.
REQ-028 Bench: store with mem_byte_en=4'b0011, wdata=32'h0000_ABCD -> port_we=1, byte_en=4'b0011 held stable until ack, mem_rdata unchanged.
REQ-029 Bench: TIMEOUT=4, no ack -> bus_err pulse exactly at the 4th BUSY cycle, mem_rdata=0, mem_stall released one cycle later.
REQ-030 Bench: reset asserted mid-MEM_BUSY, then ack after release -> port_req=0 immediately, ack ignored, state IDLE.
REQ-031 Bench: back-to-back loads on consecutive instructions -> second grant issued from MEM_DONE without passing through IDLE.
